// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LDM,
        CALC,
        FIX,
        DONE
    } div_state_e;

    localparam int          DIV_WIDTH     = 16;
    localparam int          DIV_CNT_INIT  = 16;
    localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

endpackage

// File: rtl/div_datapath.sv
// A/Q/M registers, 17-bit adder-subtractor and iteration counter of the divider.
// The controller supplies load, clear, shift and add/sub strobes each cycle.
module div_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_q_i,
    input  logic             load_m_i,
    input  logic             shift_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             eqz_o,
    output logic             a_sign_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   a_sum;
    logic [WIDTH-1:0] a_fix;

    // A is kept in 17-bit two's complement; wrap-around inside a step is harmless
    // because the post-step value always lies in [-M, M).
    always_comb begin
        m_ext   = {1'b0, m_q};
        a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        a_sum   = sub_i ? (a_shift - m_ext) : (a_shift + m_ext);
        a_fix   = a_q[WIDTH-1:0] + m_q;

        a_d   = a_q;
        q_d   = q_q;
        m_d   = m_q;
        cnt_d = cnt_q;

        if (load_q_i) begin
            q_d = data_i;
        end
        if (load_m_i) begin
            m_d   = data_i;
            a_d   = '0;
            cnt_d = CNT_W'(DIV_CNT_INIT);
        end
        if (shift_i) begin
            a_d   = a_sum;
            q_d   = {q_q[WIDTH-2:0], ~a_sum[WIDTH]};
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

    assign eqz_o    = (cnt_q == CNT_W'(1));
    assign a_sign_o = a_q[WIDTH];
    assign quot_o   = q_q;
    assign rem_o    = a_q[WIDTH] ? a_fix : a_q[WIDTH-1:0];

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential 16-bit non-restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement division (truncating toward zero).
module nonrestoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e       state_q, state_d;
    logic             load_q, load_m, shift, sub;
    logic             eqz, a_sign;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] dp_quot, dp_rem;
    logic [WIDTH-1:0] fix_quot, fix_rem, dividend;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div0_q, div0_d;
`ifdef SIGNED_DIV_EN
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;

    assign operand = data_in[WIDTH-1] ? -data_in : data_in;
`else
    assign operand = data_in;
`endif

    div_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_q_i (load_q),
        .load_m_i (load_m),
        .shift_i  (shift),
        .sub_i    (sub),
        .data_i   (operand),
        .eqz_o    (eqz),
        .a_sign_o (a_sign),
        .quot_o   (dp_quot),
        .rem_o    (dp_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero divisor still passes through FIX so every result commits from one place.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LDM;
            LDM:     state_d = (data_in == '0) ? FIX : CALC;
            CALC:    if (eqz) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_q = (state_q == IDLE) && start;
        load_m = (state_q == LDM);
        shift  = (state_q == CALC);
        sub    = ~a_sign;
        busy   = (state_q == CALC) || (state_q == FIX);
        done   = (state_q == DONE);
    end

    always_comb begin
        fix_quot = dp_quot;
        fix_rem  = dp_rem;
`ifdef SIGNED_DIV_EN
        if (dvd_neg_q != dvs_neg_q) fix_quot = -dp_quot;
        if (dvd_neg_q) fix_rem = -dp_rem;
        dividend = dvd_neg_q ? -dp_quot : dp_quot;
`else
        dividend = dp_quot;
`endif
        if (div0_q) begin
            fix_quot = WIDTH'(DIV_ZERO_QUOT);
            fix_rem  = dividend;
        end
    end

    always_comb begin
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div0_d      = div0_q;
`ifdef SIGNED_DIV_EN
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        if (load_q) dvd_neg_d = data_in[WIDTH-1];
        if (load_m) dvs_neg_d = data_in[WIDTH-1];
`endif
        if (load_q) div0_d = 1'b0;
        if (load_m) div0_d = (data_in == '0);
        if (state_q == FIX) begin
            quotient_d  = fix_quot;
            remainder_d = fix_rem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            div0_q      <= 1'b0;
`ifdef SIGNED_DIV_EN
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
`endif
        end else begin
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div0_q      <= div0_d;
`ifdef SIGNED_DIV_EN
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
`endif
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div0_q;

endmodule
